// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared defaults and FSM state encoding for the mic frequency counter
package mic_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic {
        ST_ALIGN = 1'b0,
        ST_COUNT = 1'b1
    } mic_state_e;

endpackage

// File: rtl/sync_edge_filter.sv
// rtl/sync_edge_filter.sv - input synchronizer with optional glitch filter and edge detect
module sync_edge_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_CYC  = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic toggle
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   sync_out;
    logic                   level_prev_q, level_prev_d;

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], async_in};
        level_prev_d = level;
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            level_prev_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            level_prev_q <= level_prev_d;
        end
    end

    generate
        if (GLITCH_CYC == 0) begin : g_pass
            assign level = sync_out;
        end else begin : g_filt
            localparam int               RUN_W    = $clog2(GLITCH_CYC + 1);
            localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(GLITCH_CYC - 1);

            logic             filt_q, filt_d;
            logic [RUN_W-1:0] run_q, run_d;

            // The run counter only survives while the synced level keeps disagreeing.
            always_comb begin
                filt_d = filt_q;
                run_d  = '0;
                if (sync_out != filt_q) begin
                    if (run_q == RUN_LAST) begin
                        filt_d = sync_out;
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    filt_q <= 1'b0;
                    run_q  <= '0;
                end else begin
                    filt_q <= filt_d;
                    run_q  <= run_d;
                end
            end

            assign level = filt_q;
        end
    endgenerate

    assign rise   = level & ~level_prev_q;
    assign toggle = level ^ level_prev_q;

endmodule

// File: rtl/mic_freq_counter.sv
// rtl/mic_freq_counter.sv - gated mic edge counter publishing Hz, valid strobe and in-band flag
module mic_freq_counter
    import mic_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int GLITCH_CYC  = 4,
    parameter int LO_HZ       = 900,
    parameter int HI_HZ       = 1100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate_tgl,
    input  logic             mic_in,
    output logic [CNT_W-1:0] hz,
    output logic             hz_valid,
    output logic             in_band,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic mic_rise, gate_edge;
    logic mic_level_unused, mic_toggle_unused;
    logic gate_level_unused, gate_rise_unused;

    sync_edge_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .GLITCH_CYC  (GLITCH_CYC)
    ) u_mic_filter (
        .clk      (clk),
        .rst      (rst),
        .async_in (mic_in),
        .level    (mic_level_unused),
        .rise     (mic_rise),
        .toggle   (mic_toggle_unused)
    );

    sync_edge_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .GLITCH_CYC  (0)
    ) u_gate_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (gate_tgl),
        .level    (gate_level_unused),
        .rise     (gate_rise_unused),
        .toggle   (gate_edge)
    );

    mic_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] hz_q, hz_d;
    logic             hz_valid_q, hz_valid_d;
    logic             in_band_q, in_band_d;
    logic             overflow_q, overflow_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sat_d      = sat_q;
        hz_d       = hz_q;
        hz_valid_d = 1'b0;
        in_band_d  = in_band_q;
        overflow_d = overflow_q;

        case (state_q)
            ST_ALIGN: begin
                cnt_d = '0;
                sat_d = 1'b0;
                // A mic rise landing on the opening boundary belongs to the new window.
                if (gate_edge) begin
                    state_d = ST_COUNT;
                    cnt_d   = {{(CNT_W-1){1'b0}}, mic_rise};
                end
            end
            ST_COUNT: begin
                if (gate_edge) begin
                    hz_d       = cnt_q;
                    overflow_d = sat_q;
                    in_band_d  = (int'(cnt_q) >= LO_HZ) && (int'(cnt_q) <= HI_HZ);
                    hz_valid_d = 1'b1;
                    cnt_d      = {{(CNT_W-1){1'b0}}, mic_rise};
                    sat_d      = 1'b0;
                end else if (mic_rise) begin
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_ALIGN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ALIGN;
            cnt_q      <= '0;
            sat_q      <= 1'b0;
            hz_q       <= '0;
            hz_valid_q <= 1'b0;
            in_band_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sat_q      <= sat_d;
            hz_q       <= hz_d;
            hz_valid_q <= hz_valid_d;
            in_band_q  <= in_band_d;
            overflow_q <= overflow_d;
        end
    end

    assign hz       = hz_q;
    assign hz_valid = hz_valid_q;
    assign in_band  = in_band_q;
    assign overflow = overflow_q;

endmodule
